// File: rtl/gate_pkg.sv
// Shared op encoding and bitwise gate/popcount helpers for the logic gate unit.
// Helpers work at the 64-bit maximum width; callers truncate to their own WIDTH.
package gate_pkg;
    localparam int OP_W = 3;
    localparam int MAXW = 64;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_ANDN = 3'd6;
    localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

    function automatic logic [MAXW-1:0] gate_eval(input logic [OP_W-1:0] op,
                                                  input logic [MAXW-1:0] a,
                                                  input logic [MAXW-1:0] b);
        logic [MAXW-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            OP_ANDN: r = a & ~b;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] popcount(input logic [MAXW-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < MAXW; i++) begin
            n = n + 7'(v[i]);
        end
        return n;
    endfunction
endpackage

// File: rtl/logic_gate_unit_if.sv
// Operand-in / result-out valid-ready bundle of the logic gate unit.
// slave is the unit's view, master is the producer/consumer view.
interface logic_gate_unit_if #(parameter int WIDTH = 8);
    import gate_pkg::*;
    localparam int OW = $clog2(WIDTH + 1);

    logic            in_valid;
    logic            in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [OP_W-1:0] op;
    logic            out_valid;
    logic            out_ready;
    logic [WIDTH-1:0] z;
    logic            z_any;
    logic [OW-1:0]   z_ones;
    logic            err;

    modport master (output in_valid, x, y, op, out_ready,
                    input  in_ready, out_valid, z, z_any, z_ones, err);
    modport slave  (input  in_valid, x, y, op, out_ready,
                    output in_ready, out_valid, z, z_any, z_ones, err);
endinterface

// File: rtl/gate_fifo.sv
// Generic synchronous FIFO; push ignored when full, pop ignored when empty.
// Output is the head register; while empty it holds the last head shown.
module gate_fifo #(
    parameter int WIDTH_E = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [WIDTH_E-1:0] din_i,
    output logic [WIDTH_E-1:0] dout_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH_E-1:0] mem_q [DEPTH];
    logic [WIDTH_E-1:0] last_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din_i;
            // Remember the visible head so the output stays put once drained.
            if (!empty_o) last_q <= mem_q[rd_ptr_q];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/logic_gate_unit.sv
// Bitwise gate on x/y selected by op, result + OR-flag + popcount queued in a DEPTH FIFO.
// Result at head one edge after accept when empty; in_ready is count<DEPTH from registers only.
module logic_gate_unit
    import gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    logic_gate_unit_if.slave gif
);
    localparam int OW = $clog2(WIDTH + 1);
    localparam int EW = WIDTH + 1 + OW;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic             any;
        logic [OW-1:0]    ones;
    } entry_t;

    logic [WIDTH-1:0] res;
    entry_t           in_e, head_e;
    logic             push, pop, full, empty;
    logic [CW-1:0]    count;
    logic             err_q, err_d;

    assign res  = WIDTH'(gate_eval(gif.op, MAXW'(gif.x), MAXW'(gif.y)));
    assign in_e = '{z: res, any: |res, ones: OW'(popcount(MAXW'(res)))};

    assign gif.in_ready  = (count < CW'(DEPTH));
    assign gif.out_valid = (count != '0);
    assign push          = gif.in_valid && !full;
    assign pop           = gif.out_ready && !empty;

    gate_fifo #(.WIDTH_E(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (in_e),
        .dout_o  (head_e),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign {gif.z, gif.z_any, gif.z_ones} = head_e;

    assign err_d   = err_q | (push && (gif.op == OP_RSVD));
    assign gif.err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench: expected results queued at stimulus time, popped by per-instance monitors.
// Covers WIDTH=8/DEPTH=2 and a WIDTH=1 instance.
module tb_logic_gate_unit;
    typedef struct {
        logic [63:0] z;
        logic        any;
        int          ones;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb8[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(8)) g8();
    logic_gate_unit_if #(.WIDTH(1)) g1();

    logic_gate_unit #(.WIDTH(8), .DEPTH(2)) dut8 (.clk(clk), .rst(rst), .gif(g8.slave));
    logic_gate_unit #(.WIDTH(1), .DEPTH(2)) dut1 (.clk(clk), .rst(rst), .gif(g1.slave));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic exp_t make_exp(input logic [2:0] op, input logic [63:0] a,
                                      input logic [63:0] b, input int w);
        exp_t e;
        logic [63:0] r, mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = ~(a ^ b);
            3'd6: r = a & ~b;
            default: r = 64'd0;
        endcase
        e.z = r & mask;
        e.any = (e.z != 64'd0);
        e.ones = 0;
        for (int i = 0; i < 64; i++) e.ones += int'(e.z[i]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && g8.out_valid && g8.out_ready) begin
            if (sb8.size() == 0) begin
                n_checks++;
                $display("FAIL out8_unexpected: got z=%0h, required no output", g8.z);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                chk("z8", 64'(g8.z), e.z);
                chk("z_any8", 64'(g8.z_any), 64'(e.any));
                chk("z_ones8", 64'(g8.z_ones), 64'(e.ones));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && g1.out_valid && g1.out_ready) begin
            if (sb1.size() == 0) begin
                n_checks++;
                $display("FAIL out1_unexpected: got z=%0h, required no output", g1.z);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                chk("z1", 64'(g1.z), e.z);
                chk("z_any1", 64'(g1.z_any), 64'(e.any));
                chk("z_ones1", 64'(g1.z_ones), 64'(e.ones));
            end
        end
    end

    task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input bit push_model, input bit stream_chk);
        int t = 0;
        bit done = 0;
        g8.in_valid = 1'b1; g8.op = op; g8.x = a; g8.y = b;
        while (!done) begin
            @(negedge clk);
            if (stream_chk) begin
                chk("stream_in_ready", 64'(g8.in_ready), 64'd1);
                chk("stream_out_valid", 64'(g8.out_valid), 64'd1);
            end
            if (g8.in_ready) begin
                if (push_model) sb8.push_back(make_exp(op, 64'(a), 64'(b), 8));
                @(posedge clk); #1;
                done = 1;
            end else if (++t > 50) begin
                chk("send8_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
        g8.in_valid = 1'b0;
    endtask

    task automatic send1(input logic [2:0] op, input logic a, input logic b);
        int t = 0;
        bit done = 0;
        g1.in_valid = 1'b1; g1.op = op; g1.x = a; g1.y = b;
        while (!done) begin
            @(negedge clk);
            if (g1.in_ready) begin
                sb1.push_back(make_exp(op, 64'(a), 64'(b), 1));
                @(posedge clk); #1;
                done = 1;
            end else if (++t > 50) begin
                chk("send1_timeout", 64'd1, 64'd0);
                done = 1;
            end
        end
        g1.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb8.size() != 0 || sb1.size() != 0 || g8.out_valid || g1.out_valid) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_sb8_empty", 64'(sb8.size()), 64'd0);
        chk("drain_sb1_empty", 64'(sb1.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tz [7] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h30};
        int         to [7] = '{2, 6, 4, 6, 2, 4, 2};
        exp_t e;

        g8.in_valid = 0; g8.x = 0; g8.y = 0; g8.op = 0; g8.out_ready = 0;
        g1.in_valid = 0; g1.x = 0; g1.y = 0; g1.op = 0; g1.out_ready = 1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(g8.in_ready), 64'd1);
        chk("rst_out_valid", 64'(g8.out_valid), 64'd0);
        chk("rst_z", 64'(g8.z), 64'd0);
        chk("rst_z_any", 64'(g8.z_any), 64'd0);
        chk("rst_z_ones", 64'(g8.z_ones), 64'd0);
        chk("rst_err", 64'(g8.err), 64'd0);
        chk("rst_err1", 64'(g1.err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        g8.out_ready = 1'b1;

        // Op sweep against literal results
        for (int i = 0; i < 7; i++) begin
            e.z = 64'(tz[i]); e.any = 1'b1; e.ones = to[i];
            sb8.push_back(e);
            send8(3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
        end
        drain();
        chk("sweep_err", 64'(g8.err), 64'd0);

        // Reserved op: zero result, sticky err
        send8(3'd7, 8'hFF, 8'hFF, 1'b1, 1'b0);
        chk("rsvd_err_set", 64'(g8.err), 64'd1);
        for (int i = 0; i < 10; i++) begin
            send8(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        end
        drain();
        chk("rsvd_err_sticky", 64'(g8.err), 64'd1);

        // Backpressure with a full FIFO
        g8.out_ready = 1'b0;
        g8.in_valid = 1'b1; g8.op = 3'd1; g8.x = 8'h01; g8.y = 8'h02;
        @(negedge clk); chk("bp_rdy1", 64'(g8.in_ready), 64'd1);
        sb8.push_back(make_exp(3'd1, 64'h01, 64'h02, 8));
        @(posedge clk); #1;
        g8.x = 8'h04; g8.y = 8'h08;
        @(negedge clk); chk("bp_rdy2", 64'(g8.in_ready), 64'd1);
        sb8.push_back(make_exp(3'd1, 64'h04, 64'h08, 8));
        @(posedge clk); #1;
        g8.x = 8'h10; g8.y = 8'h20;
        @(negedge clk); chk("bp_full_rdy", 64'(g8.in_ready), 64'd0);
        chk("bp_full_valid", 64'(g8.out_valid), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_held", 64'(g8.in_ready), 64'd0);
        @(posedge clk); #1;
        g8.out_ready = 1'b1;
        @(negedge clk); chk("bp_no_same_cycle", 64'(g8.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_third_accept", 64'(g8.in_ready), 64'd1);
        sb8.push_back(make_exp(3'd1, 64'h10, 64'h20, 8));
        @(posedge clk); #1;
        g8.in_valid = 1'b0;
        drain();

        // Streaming at count=1 with pointer wrap
        send8(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            send8(3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
        end
        drain();

        // Reset mid-operation
        g8.out_ready = 1'b0;
        send8(3'd7, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        send8(3'd1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        chk("pre_rst_err", 64'(g8.err), 64'd1);
        chk("pre_rst_full", 64'(g8.in_ready), 64'd0);
        rst = 1'b1;
        sb8.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 64'(g8.out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(g8.in_ready), 64'd1);
        chk("mid_rst_err", 64'(g8.err), 64'd0);
        chk("mid_rst_z", 64'(g8.z), 64'd0);
        @(posedge clk); #1;
        g8.out_ready = 1'b1;
        send8(3'd2, 8'hA5, 8'h0F, 1'b1, 1'b0);
        drain();

        // WIDTH=1 truth table and a few random ops
        for (int i = 0; i < 4; i++) begin
            send1(3'd1, 1'(i >> 1), 1'(i));
        end
        for (int i = 0; i < 8; i++) begin
            send1(3'($urandom_range(0, 6)), 1'($urandom), 1'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
